// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing a single bitwise logic unit among N_REQ requesters.
// Each grant captures the winner's opcode/operands; the tagged result is registered one cycle later.
module logic_unit_arbiter #(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 8,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [3*N_REQ-1:0]     op,
    input  logic [WIDTH*N_REQ-1:0] a,
    input  logic [WIDTH*N_REQ-1:0] b,
    output logic [N_REQ-1:0]       gnt,
    output logic                   busy,
    output logic                   res_valid,
    output logic [IDW-1:0]         res_id,
    output logic [WIDTH-1:0]       res_data
);

    localparam logic [0:0]   IDLE    = 1'b0;
    localparam logic [0:0]   EXEC    = 1'b1;
    localparam logic [IDW:0] N_REQ_W = (IDW+1)'(N_REQ);

    logic [0:0]       state_r;
    logic [IDW-1:0]   ptr_r;
    logic [N_REQ-1:0] gnt_r;
    logic             res_valid_r;
    logic [IDW-1:0]   res_id_r;
    logic [WIDTH-1:0] res_data_r;
    logic [2:0]       op_l_r;
    logic [WIDTH-1:0] a_l_r;
    logic [WIDTH-1:0] b_l_r;
    logic [IDW-1:0]   id_l_r;

    logic             win_found_s;
    logic [IDW-1:0]   win_idx_s;
    logic [IDW:0]     cand_s;
    logic [N_REQ-1:0] win_onehot_s;
    logic [2:0]       win_op_s;
    logic [WIDTH-1:0] win_a_s;
    logic [WIDTH-1:0] win_b_s;

    function automatic logic [WIDTH-1:0] logic_eval(
        input logic [2:0]       op_v,
        input logic [WIDTH-1:0] a_v,
        input logic [WIDTH-1:0] b_v
    );
        logic [WIDTH-1:0] r_v;
        case (op_v)
            3'd0:    r_v = a_v & b_v;
            3'd1:    r_v = a_v | b_v;
            3'd2:    r_v = ~(a_v & b_v);
            3'd3:    r_v = ~(a_v | b_v);
            3'd4:    r_v = a_v ^ b_v;
            3'd5:    r_v = ~(a_v ^ b_v);
            3'd6:    r_v = ~a_v;
            3'd7:    r_v = a_v;
            default: r_v = a_v;
        endcase
        return r_v;
    endfunction

    // Round-robin search: scan from the farthest candidate back to ptr+1 so the nearest request wins.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand_s = {1'b0, ptr_r} + (IDW+1)'(k);
            cand_s = (cand_s >= N_REQ_W) ? (cand_s - N_REQ_W) : cand_s;
            win_idx_s   = req[cand_s[IDW-1:0]] ? cand_s[IDW-1:0] : win_idx_s;
            win_found_s = win_found_s | req[cand_s[IDW-1:0]];
        end
    end

    // Steer the winner's opcode and operands and build its one-hot grant.
    always_comb begin
        win_onehot_s = '0;
        win_op_s     = 3'd0;
        win_a_s      = '0;
        win_b_s      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx_s == IDW'(i)) begin
                win_onehot_s[i] = 1'b1;
                win_op_s        = op[3*i +: 3];
                win_a_s         = a[WIDTH*i +: WIDTH];
                win_b_s         = b[WIDTH*i +: WIDTH];
            end else begin
                win_onehot_s[i] = 1'b0;
            end
        end
    end

    // Two-state sequencer: grant and capture in IDLE, evaluate and publish in EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            ptr_r       <= IDW'(N_REQ-1);
            gnt_r       <= '0;
            res_valid_r <= 1'b0;
            res_id_r    <= '0;
            res_data_r  <= '0;
            op_l_r      <= 3'd0;
            a_l_r       <= '0;
            b_l_r       <= '0;
            id_l_r      <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    res_valid_r <= 1'b0;
                    if (win_found_s) begin
                        gnt_r   <= win_onehot_s;
                        ptr_r   <= win_idx_s;
                        id_l_r  <= win_idx_s;
                        op_l_r  <= win_op_s;
                        a_l_r   <= win_a_s;
                        b_l_r   <= win_b_s;
                        state_r <= EXEC;
                    end else begin
                        gnt_r   <= '0;
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    res_data_r  <= logic_eval(op_l_r, a_l_r, b_l_r);
                    res_id_r    <= id_l_r;
                    res_valid_r <= 1'b1;
                    gnt_r       <= '0;
                    state_r     <= IDLE;
                end
                default: begin
                    gnt_r       <= '0;
                    res_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_r;
    assign busy      = (state_r == EXEC);
    assign res_valid = res_valid_r;
    assign res_id    = res_id_r;
    assign res_data  = res_data_r;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: stimulus pushes expected {id,data} into a scoreboard,
// an independent monitor pops and compares on every res_valid strobe.
module tb_logic_unit_arbiter;

    localparam int N_REQ = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                   clk;
    logic                   rst_n;
    logic [N_REQ-1:0]       req;
    logic [3*N_REQ-1:0]     op;
    logic [WIDTH*N_REQ-1:0] a;
    logic [WIDTH*N_REQ-1:0] b;
    logic [N_REQ-1:0]       gnt;
    logic                   busy;
    logic                   res_valid;
    logic [IDW-1:0]         res_id;
    logic [WIDTH-1:0]       res_data;

    int checks = 0;
    int errors = 0;
    logic [IDW+WIDTH-1:0] sb_q[$];
    logic [WIDTH-1:0] last_data;

    logic [2:0] tbl_op  [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [7:0] tbl_exp [8] = '{8'h24, 8'hBD, 8'hDB, 8'h42, 8'h99, 8'h66, 8'h5A, 8'hA5};
    logic [2:0] f_op  [4] = '{3'd0, 3'd1, 3'd4, 3'd7};
    logic [7:0] f_a   [4] = '{8'hA5, 8'hF0, 8'hFF, 8'h5A};
    logic [7:0] f_b   [4] = '{8'h3C, 8'h0F, 8'h0F, 8'h00};
    logic [7:0] f_exp [4] = '{8'h24, 8'hFF, 8'hF0, 8'h5A};

    logic_unit_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op(op), .a(a), .b(b),
        .gnt(gnt), .busy(busy), .res_valid(res_valid), .res_id(res_id), .res_data(res_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every result strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got id %0d data %0h expected none", res_id, res_data);
            end else begin
                logic [IDW+WIDTH-1:0] e;
                e = sb_q.pop_front();
                check("res_id", 32'(res_id), 32'(e[IDW+WIDTH-1:WIDTH]));
                check("res_data", 32'(res_data), 32'(e[WIDTH-1:0]));
            end
        end
    end

    task automatic do_op(input int idx, input logic [2:0] o, input logic [7:0] av,
                         input logic [7:0] bv, input logic [7:0] exp, input bit clobber);
        @(negedge clk);
        req[idx] = 1'b1;
        op[3*idx +: 3] = o;
        a[8*idx +: 8]  = av;
        b[8*idx +: 8]  = bv;
        @(posedge clk);
        #1;
        check("gnt", 32'(gnt), 32'(4'b0001 << idx));
        check("busy_exec", 32'(busy), 32'd1);
        sb_q.push_back({IDW'(idx), exp});
        last_data = exp;
        if (clobber) begin
            a[8*idx +: 8] = 8'h00;
            b[8*idx +: 8] = 8'h00;
            op[3*idx +: 3] = 3'd0;
        end
        @(negedge clk);
        req[idx] = 1'b0;
        @(posedge clk);
        #1;
        check("gnt_clear", 32'(gnt), 32'd0);
    endtask

    initial begin
        int prev;
        int w;
        rst_n = 1'b0;
        req = '0;
        op = '0;
        a = '0;
        b = '0;
        last_data = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_id", 32'(res_id), 32'd0);
        check("rst_data", 32'(res_data), 32'd0);
        rst_n = 1'b1;

        // All opcodes on requester 0
        for (int i = 0; i < 8; i++) begin
            do_op(0, tbl_op[i], 8'hA5, 8'h3C, tbl_exp[i], 1'b0);
        end

        // Reset asserted mid-EXEC discards the operation
        @(negedge clk);
        req[0] = 1'b1;
        op[2:0] = 3'd1;
        @(posedge clk);
        #1;
        check("pre_rst_gnt", 32'(gnt), 32'd1);
        #1;
        rst_n = 1'b0;
        req = '0;
        #1;
        check("mid_rst_gnt", 32'(gnt), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(res_valid), 32'd0);
        check("mid_rst_data", 32'(res_data), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_data", 32'(res_data), 32'd0);

        // Fairness: all four requesting, each re-asserts two cycles after dropping
        for (int i = 0; i < 4; i++) begin
            op[3*i +: 3] = f_op[i];
            a[8*i +: 8]  = f_a[i];
            b[8*i +: 8]  = f_b[i];
        end
        req = 4'b1111;
        prev = -1;
        for (int g = 0; g < 8; g++) begin
            w = g % 4;
            @(posedge clk);
            #1;
            check("rr_gnt", 32'(gnt), 32'(4'b0001 << w));
            check("rr_busy", 32'(busy), 32'd1);
            sb_q.push_back({IDW'(w), f_exp[w]});
            @(negedge clk);
            req[w] = 1'b0;
            if (prev >= 0) req[prev] = 1'b1;
            prev = w;
            @(posedge clk);
            #1;
            check("rr_idle", 32'(busy), 32'd0);
        end
        @(negedge clk);
        req = '0;
        repeat (2) @(negedge clk);

        // Single NAND on requester 2
        do_op(2, 3'd2, 8'hF0, 8'hCC, 8'h3F, 1'b0);
        // Operand capture: operands clobbered during the grant cycle
        do_op(1, 3'd4, 8'h0F, 8'hF0, 8'hFF, 1'b1);

        // Idle: nothing moves, result holds
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_gnt", 32'(gnt), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_valid", 32'(res_valid), 32'd0);
            check("idle_data", 32'(res_data), 32'(last_data));
        end

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
